// File: rtl/mem_pkg.sv
// Constants and types shared by the data-memory load and store paths.
package mem_pkg;

  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int MEM_UNS_BIT = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

endpackage

// File: rtl/load_extend.sv
// Lane-0 size select with sign or zero extension of SRAM read data.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ext
);

  always_comb begin
    ext = '0;
    case (size)
      MEM_BYTE: ext = {{24{~uns & data[7]}}, data[7:0]};
      MEM_HALF: ext = {{16{~uns & data[15]}}, data[15:0]};
      MEM_WORD: ext = data;
      default:  ext = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load path: issues the SRAM read, waits RD_LATENCY cycles, returns extended data.
// Optional MISALIGN_CHECK_EN rejects misaligned HALF/WORD loads with a misalign pulse.
//
// state | meaning
// IDLE  | no load in flight, accepting requests
// WAIT  | address issued, counting down SRAM read latency
// RESP  | resp_valid (or misalign) pulse cycle, accepting requests
module load_unit
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [4:0]        mem_op,
  input  logic [31:0]       addr,
  input  logic [4:0]        rd_idx,
  input  logic              flush,
  input  logic [31:0]       dataout,
  output logic [ADDR_W-1:0] addrout,
  output logic              ren,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd
`ifdef MISALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] ext_data;
  logic        accept;
  logic        misaligned;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_W];

  assign accept = req_valid && (mem_op[4:3] == MEM_READ) && !flush && (state != WAIT);

`ifdef MISALIGN_CHECK_EN
  assign misaligned = ((mem_op[1:0] == MEM_HALF) && addr[0]) ||
                      ((mem_op[1:0] == MEM_WORD) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Combinational so the upstream stage freezes in the request cycle itself.
  assign stall = (state == WAIT) || (accept && !misaligned);

  load_extend u_extend (
    .data (dataout),
    .size (op_q[1:0]),
    .uns  (op_q[MEM_UNS_BIT]),
    .ext  (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      addrout    <= '0;
      ren        <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
`ifdef MISALIGN_CHECK_EN
      misalign   <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign   <= 1'b0;
`endif
      case (state)
        IDLE, RESP: begin
          if (accept && misaligned) begin
            state <= RESP;
            ren   <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            misalign <= 1'b1;
`endif
          end else if (accept) begin
            addrout <= addr[ADDR_W-1:0];
            ren     <= 1'b1;
            op_q    <= mem_op[2:0];
            rd_q    <= rd_idx;
            cnt     <= LAT;
            state   <= WAIT;
          end else begin
            ren   <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT: begin
          if (flush) begin
            ren   <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == 3'd1) begin
            resp_data  <= ext_data;
            resp_rd    <= rd_q;
            resp_valid <= 1'b1;
            ren        <= 1'b0;
            cnt        <= '0;
            state      <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          ren   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Read-side counterpart of the data-memory store path.
- Accepts a load request from the MEM stage and issues the address to the synchronous data SRAM.
- Waits the SRAM read latency, then extracts and extends byte/half/word data and returns it with the destination register index for writeback.
- Stalls the pipeline while a load is in flight.

Parameters:
- RD_LATENCY, 1: SRAM cycles from address issue to valid dataout; legal range 1-4.
- ADDR_W, 14: SRAM word-address width; taken from addr[ADDR_W-1:0].

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  MEM stage presents a memory op
- mem_op  input  5  [4:3] access type, [2] unsigned flag, [1:0] size
- addr  input  32  effective address
- rd_idx  input  5  destination register
- flush  input  1  squash the in-flight load
- dataout  input  32  SRAM read data
- addrout  output  ADDR_W  SRAM address
- ren  output  1  SRAM read strobe
- stall  output  1  hold upstream pipeline
- resp_valid  output  1  load result valid this cycle
- resp_data  output  32  aligned, extended load data
- resp_rd  output  5  destination register of resp_data

Behaviour:
- Reset (async, rst_n=0): state IDLE; ren=0, stall=0, resp_valid=0, resp_data=0, resp_rd=0, addrout=0, latency counter=0.
- Load request: req_valid=1 and mem_op[4:3]==MEM_READ. Any other combination, including MEM_WRITE, is ignored; no state change.
- Sub-word data sits in lane 0, matching the store path, which writes bytes/halves at wen 4'b0001/4'b0011 without lane shift.
  - BYTE takes dataout[7:0].
  - HALF takes dataout[15:0].
  - WORD takes all 32 bits.
  - addr[1:0] does not select a lane.
- Extension: mem_op[2]=0 sign-extends; mem_op[2]=1 zero-extends. WORD ignores mem_op[2]. Size code 2'b11 returns 0 with resp_valid still asserted.
- State IDLE:
  - On an accepted load: addrout<=addr[ADDR_W-1:0], ren<=1, latch op/rd_idx, counter<=RD_LATENCY, go to WAIT.
  - stall is combinational: asserted in the same cycle as the accepted request.
- State WAIT:
  - ren held 1, stall=1, counter decrements each cycle.
  - At counter==1: capture extended dataout into resp_data, pulse resp_valid for exactly one cycle, drive resp_rd, go to RESP.
  - Total latency from request cycle to resp_valid is RD_LATENCY+1 clocks.
- State RESP:
  - stall=0, ren=0.
  - A new load in this cycle is accepted exactly as from IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- resp_data/resp_rd hold their last value after resp_valid drops.
- flush:
  - In WAIT: return to IDLE next cycle; resp_valid stays 0; ren and stall drop next cycle.
  - With a request in the same cycle: the request is discarded.
  - In RESP or IDLE: no effect.
- A request while in WAIT is impossible because stall is high. Such a request is ignored.
- Reset mid-load: immediate return to IDLE; no response is ever issued.

Optional Feature:
- MISALIGN_CHECK_EN, defined:
  - Adds output misalign (1 bit).
  - A HALF load with addr[0]=1 or a WORD load with addr[1:0]!=0 is not issued to the SRAM (ren stays 0).
  - The unit goes straight to RESP with resp_valid=0 and misalign=1 for one cycle.
  - misalign resets to 0.
- Undefined: no port; all loads are issued regardless of alignment.

Decomposition:
- Shared package mem_pkg:
  - MEM_READ=2'b01, MEM_WRITE=2'b10.
  - MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - Unsigned-bit index 2.
  - State enum {IDLE, WAIT, RESP}.
  - Store and load paths share these constants.
- One sub-module, load_extend: purely combinational size select and sign/zero extension, instantiated once.

Test Plan:
- RD_LATENCY=1, LB signed, dataout=32'h000000F0: request at cycle 0 -> stall at cycle 0, resp_valid at cycle 2, resp_data=32'hFFFFFFF0.
- LHU, dataout=32'h1234_8001 -> resp_data=32'h0000_8001; LH same data -> 32'hFFFF_8001.
- RD_LATENCY=3, LW addr=32'h0000_4008: addrout=14'h0008 while ren=1 for 3 cycles -> resp_valid on cycle 4, stall low from cycle 4.
- Back-to-back LW rd=5 then LB rd=6 presented in the RESP cycle -> two responses two cycles apart, resp_rd 5 then 6.
- flush in WAIT -> resp_valid never asserts, stall low next cycle; rst_n low in WAIT -> all outputs 0 immediately.
- With MISALIGN_CHECK_EN: LW addr=32'h2 -> ren=0, misalign=1 for one cycle, resp_valid=0.
